// File: rtl/bip_control_if.sv
// Bus between the BIP control unit and its surroundings.
// The bus carries the program memory fetch, the data memory strobes and
// the DataPath controls, plus START, HALTED and CYCLE_CNT.
//   master : the control unit. It drives addresses, strobes and status,
//            and it reads START and PM_DATA.
//   slave  : program memory, DataPath and the host side.
interface bip_control_if #(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int OPD_W = 11,
  parameter int CNT_W = 32
);
  logic                   START;
  logic [OPC_W+OPD_W-1:0] PM_DATA;
  logic [PC_W-1:0]        PM_ADDR;
  logic [OPD_W-1:0]       DM_ADDR;
  logic                   RD_RAM;
  logic                   WR_RAM;
  logic [OPD_W-1:0]       OPERAND;
  logic [1:0]             SEL_A;
  logic                   SEL_B;
  logic                   WR_ACC;
  logic                   OP;
  logic                   HALTED;
  logic [CNT_W-1:0]       CYCLE_CNT;

  modport master (
    input  START, PM_DATA,
    output PM_ADDR, DM_ADDR, RD_RAM, WR_RAM, OPERAND,
           SEL_A, SEL_B, WR_ACC, OP, HALTED, CYCLE_CNT
  );

  modport slave (
    output START, PM_DATA,
    input  PM_ADDR, DM_ADDR, RD_RAM, WR_RAM, OPERAND,
           SEL_A, SEL_B, WR_ACC, OP, HALTED, CYCLE_CNT
  );
endinterface

// File: rtl/bip_control.sv
// Control unit of the BIP accumulator processor.
// The unit fetches 16-bit instructions from synchronous program memory.
// It decodes them and drives the DataPath and data memory controls.
// Each instruction takes FETCH -> DECODE -> EXEC. HLT stops the unit in
// HALT until RESET.
// Ports:
//   CLK   : rising-edge clock
//   RESET : synchronous, active-high reset
//   bus   : bip_control_if.master. It carries START and PM_DATA in, and
//           PM_ADDR, DM_ADDR, RD_RAM, WR_RAM, OPERAND, SEL_A, SEL_B,
//           WR_ACC, OP, HALTED and CYCLE_CNT out.
module bip_control #(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int OPD_W = 11,
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  bip_control_if.master bus
);

  localparam int IW = OPC_W + OPD_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = OPC_W'(5'd0);
  localparam logic [OPC_W-1:0] OPC_STO  = OPC_W'(5'd1);
  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(5'd2);
  localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(5'd3);
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(5'd4);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'd5);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(5'd6);
  localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(5'd7);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t           state_r;
  logic [PC_W-1:0]  pc_r;
  logic [IW-1:0]    ir_r;
  logic [CNT_W-1:0] cnt_r;
  logic             wr_acc_r;
  logic             wr_ram_r;
  logic [1:0]       sel_a_r;
  logic             sel_b_r;
  logic             op_r;
  logic             halted_r;

  logic [OPC_W-1:0] pm_opc_s;
  logic [OPC_W-1:0] ir_opc_s;
  logic [OPD_W-1:0] opd_s;
  logic             rd_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Opcodes that read data memory. These keep RD_RAM high so DM_IN is valid in EXEC.
  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

  assign pm_opc_s = bus.PM_DATA[IW-1:OPD_W];
  assign ir_opc_s = ir_r[IW-1:OPD_W];

  // The counter sticks at all-ones instead of wrapping.
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r
                                              : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Operand and read strobe. In DECODE they come straight from the memory
  // word, because IR is only loaded at the end of that cycle.
  always_comb begin
    opd_s = ir_r[OPD_W-1:0];
    rd_s  = 1'b0;
    case (state_r)
      ST_DECODE: begin
        opd_s = bus.PM_DATA[OPD_W-1:0];
        rd_s  = is_mem_op(pm_opc_s);
      end
      ST_EXEC: begin
        opd_s = ir_r[OPD_W-1:0];
        rd_s  = is_mem_op(ir_opc_s);
      end
      default: begin
        opd_s = ir_r[OPD_W-1:0];
        rd_s  = 1'b0;
      end
    endcase
  end

  // Sequencer. It holds PC, IR, the cycle counter and the registered EXEC controls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PC_W{1'b0}};
      ir_r     <= {IW{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      wr_acc_r <= 1'b0;
      wr_ram_r <= 1'b0;
      sel_a_r  <= 2'd0;
      sel_b_r  <= 1'b0;
      op_r     <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      // The EXEC controls are one-cycle pulses. Only DECODE can set them.
      wr_acc_r <= 1'b0;
      wr_ram_r <= 1'b0;
      sel_a_r  <= 2'd0;
      sel_b_r  <= 1'b0;
      op_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.START) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          cnt_r   <= cnt_inc_s;
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          cnt_r <= cnt_inc_s;
          ir_r  <= bus.PM_DATA;
          if (pm_opc_s == OPC_HLT) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
            case (pm_opc_s)
              OPC_STO:  wr_ram_r <= 1'b1;
              OPC_LD:   begin sel_a_r <= 2'd0; wr_acc_r <= 1'b1; end
              OPC_LDI:  begin sel_a_r <= 2'd1; wr_acc_r <= 1'b1; end
              OPC_ADD:  begin sel_a_r <= 2'd2; sel_b_r <= 1'b0; op_r <= 1'b1; wr_acc_r <= 1'b1; end
              OPC_ADDI: begin sel_a_r <= 2'd2; sel_b_r <= 1'b1; op_r <= 1'b1; wr_acc_r <= 1'b1; end
              OPC_SUB:  begin sel_a_r <= 2'd2; sel_b_r <= 1'b0; op_r <= 1'b0; wr_acc_r <= 1'b1; end
              OPC_SUBI: begin sel_a_r <= 2'd2; sel_b_r <= 1'b1; op_r <= 1'b0; wr_acc_r <= 1'b1; end
              default:  wr_acc_r <= 1'b0;  // unknown opcode: NOP
            endcase
          end
        end
        ST_EXEC: begin
          cnt_r   <= cnt_inc_s;
          pc_r    <= pc_r + PC_W'(1'b1);
          state_r <= ST_FETCH;
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.PM_ADDR   = pc_r;
  assign bus.DM_ADDR   = opd_s;
  assign bus.OPERAND   = opd_s;
  assign bus.RD_RAM    = rd_s;
  assign bus.WR_RAM    = wr_ram_r;
  assign bus.WR_ACC    = wr_acc_r;
  assign bus.SEL_A     = sel_a_r;
  assign bus.SEL_B     = sel_b_r;
  assign bus.OP        = op_r;
  assign bus.HALTED    = halted_r;
  assign bus.CYCLE_CNT = cnt_r;

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control.
// An instruction-level model expands each program into the per-cycle
// outputs the unit must show. One compare process checks both DUTs
// against that trace on every falling edge. Literal end-of-program values
// pin the model.
module tb_bip_control;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  bip_control_if #(.PC_W(11), .OPC_W(5), .OPD_W(11), .CNT_W(32)) bus_a ();
  bip_control_if #(.PC_W(2),  .OPC_W(5), .OPD_W(11), .CNT_W(3))  bus_b ();

  bip_control #(.PC_W(11), .OPC_W(5), .OPD_W(11), .CNT_W(32)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a)
  );
  bip_control #(.PC_W(2), .OPC_W(5), .OPD_W(11), .CNT_W(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b)
  );

  // Program memory of DUT A.
  logic [15:0] mem_a [0:2047];
  always @(posedge CLK) bus_a.PM_DATA <= mem_a[bus_a.PM_ADDR];

  // DUT B memory holds NOPs. Once address 1 has been reached, address 0 reads as HLT.
  logic pass2_b = 1'b0;
  always @(posedge CLK) begin
    bus_b.PM_DATA <= (pass2_b && bus_b.PM_ADDR == 2'd0) ? 16'h0000 : 16'h4000;
    if (bus_b.PM_ADDR == 2'd1) pass2_b <= 1'b1;
  end

  typedef struct packed {
    logic [10:0] pm_addr;
    logic [10:0] dm_addr;
    logic [10:0] operand;
    logic        rd;
    logic        wr_ram;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        wr_acc;
    logic        halted;
    logic [31:0] cnt;
  } rec_t;

  rec_t        qa[$];
  rec_t        qb[$];
  logic [15:0] stream[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmp_rec(input string tag, input rec_t e, input rec_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got pm=%h dm=%h opd=%h rd=%b wr=%b sa=%0d sb=%b op=%b wa=%b h=%b cnt=%0d expected pm=%h dm=%h opd=%h rd=%b wr=%b sa=%0d sb=%b op=%b wa=%b h=%b cnt=%0d",
               tag, $time, a.pm_addr, a.dm_addr, a.operand, a.rd, a.wr_ram, a.sel_a, a.sel_b, a.op, a.wr_acc, a.halted, a.cnt,
               e.pm_addr, e.dm_addr, e.operand, e.rd, e.wr_ram, e.sel_a, e.sel_b, e.op, e.wr_acc, e.halted, e.cnt);
    end
  endtask

  // Expand the fetched instruction stream into the expected per-cycle outputs.
  task automatic model_run(input int which, input int pc_w, input int cnt_w, input int n_halt);
    rec_t        r;
    logic [4:0]  opc;
    logic [10:0] opd;
    logic [10:0] ir_opd = 11'd0;
    int          pc = 0;
    longint      cnt = 0;
    longint      cmax = (64'd1 << cnt_w) - 64'd1;
    for (int idx = 0; idx < stream.size(); idx++) begin
      opc = stream[idx][15:11];
      opd = stream[idx][10:0];
      r = '0; r.pm_addr = 11'(pc); r.dm_addr = ir_opd; r.operand = ir_opd; r.cnt = 32'(cnt);
      if (which == 0) qa.push_back(r); else qb.push_back(r);
      if (cnt < cmax) cnt++;
      r = '0; r.pm_addr = 11'(pc); r.dm_addr = opd; r.operand = opd; r.cnt = 32'(cnt);
      r.rd = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
      if (which == 0) qa.push_back(r); else qb.push_back(r);
      if (cnt < cmax) cnt++;
      ir_opd = opd;
      if (opc == 5'd0) begin
        r = '0; r.pm_addr = 11'(pc); r.dm_addr = opd; r.operand = opd; r.halted = 1'b1; r.cnt = 32'(cnt);
        for (int h = 0; h < n_halt; h++) begin
          if (which == 0) qa.push_back(r); else qb.push_back(r);
        end
        break;
      end
      r = '0; r.pm_addr = 11'(pc); r.dm_addr = opd; r.operand = opd; r.cnt = 32'(cnt);
      r.rd = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
      case (opc)
        5'd1: r.wr_ram = 1'b1;
        5'd2: r.wr_acc = 1'b1;
        5'd3: begin r.sel_a = 2'd1; r.wr_acc = 1'b1; end
        5'd4: begin r.sel_a = 2'd2; r.op = 1'b1; r.wr_acc = 1'b1; end
        5'd5: begin r.sel_a = 2'd2; r.sel_b = 1'b1; r.op = 1'b1; r.wr_acc = 1'b1; end
        5'd6: begin r.sel_a = 2'd2; r.wr_acc = 1'b1; end
        5'd7: begin r.sel_a = 2'd2; r.sel_b = 1'b1; r.wr_acc = 1'b1; end
        default: r.wr_acc = 1'b0;
      endcase
      if (which == 0) qa.push_back(r); else qb.push_back(r);
      if (cnt < cmax) cnt++;
      pc = (pc + 1) % (1 << pc_w);
    end
  endtask

  // Single compare process for both DUTs.
  rec_t ea, aa, eb, ab;
  always @(negedge CLK) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      aa = '0;
      aa.pm_addr = bus_a.PM_ADDR; aa.dm_addr = bus_a.DM_ADDR; aa.operand = bus_a.OPERAND;
      aa.rd = bus_a.RD_RAM; aa.wr_ram = bus_a.WR_RAM; aa.sel_a = bus_a.SEL_A; aa.sel_b = bus_a.SEL_B;
      aa.op = bus_a.OP; aa.wr_acc = bus_a.WR_ACC; aa.halted = bus_a.HALTED; aa.cnt = bus_a.CYCLE_CNT;
      cmp_rec("trace_A", ea, aa);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      ab = '0;
      ab.pm_addr = {9'd0, bus_b.PM_ADDR}; ab.dm_addr = bus_b.DM_ADDR; ab.operand = bus_b.OPERAND;
      ab.rd = bus_b.RD_RAM; ab.wr_ram = bus_b.WR_RAM; ab.sel_a = bus_b.SEL_A; ab.sel_b = bus_b.SEL_B;
      ab.op = bus_b.OP; ab.wr_acc = bus_b.WR_ACC; ab.halted = bus_b.HALTED; ab.cnt = {29'd0, bus_b.CYCLE_CNT};
      cmp_rec("trace_B", eb, ab);
    end
  end

  task automatic reset_all();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
  endtask

  task automatic start_a();
    bus_a.START = 1'b1;
    @(posedge CLK); #1 bus_a.START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 2000) begin
      @(posedge CLK); n++;
    end
    #1;
    checks++;
    if (qa.size() > 0 || qb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", qa.size() + qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic load_a();
    for (int i = 0; i < 2048; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < stream.size(); i++) mem_a[i] = stream[i];
  endtask

  initial begin
    rec_t idle_r;
    int   n;
    idle_r = '0;
    RESET = 1'b1;
    bus_a.START = 1'b0;
    bus_b.START = 1'b0;
    stream = '{16'h0000};
    load_a();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset values
    chk("rst_pm_addr", 32'(bus_a.PM_ADDR), 32'd0);
    chk("rst_cycle_cnt", bus_a.CYCLE_CNT, 32'd0);
    chk("rst_strobes", {28'd0, bus_a.RD_RAM, bus_a.WR_RAM, bus_a.WR_ACC, bus_a.HALTED}, 32'd0);
    chk("rst_sel_op", {28'd0, bus_a.SEL_A, bus_a.SEL_B, bus_a.OP}, 32'd0);
    chk("rst_operand", {10'd0, bus_a.OPERAND, bus_a.DM_ADDR}, 32'd0);

    // IDLE with START=0 for 20 cycles: nothing moves
    for (int i = 0; i < 20; i++) begin qa.push_back(idle_r); qb.push_back(idle_r); end
    drain();

    // LDI 5; ADDI 3; STO 7; HLT, then START held high while halted
    stream = '{16'h1805, 16'h2803, 16'h0807, 16'h0000};
    load_a();
    reset_all();
    start_a();
    model_run(0, 11, 32, 24);
    chk("model_len_p1", 32'(qa.size()), 32'd35);
    n = 0;
    while (!bus_a.HALTED && n < 100) begin @(posedge CLK); #1; n++; end
    chk("p1_reached_halt", {31'd0, bus_a.HALTED}, 32'd1);
    bus_a.START = 1'b1;
    drain();
    bus_a.START = 1'b0;
    chk("p1_halted", {31'd0, bus_a.HALTED}, 32'd1);
    chk("p1_pc", 32'(bus_a.PM_ADDR), 32'd3);
    chk("p1_cycle_cnt", bus_a.CYCLE_CNT, 32'd11);

    // LD 2; SUB 4; HLT
    stream = '{16'h1002, 16'h3004, 16'h0000};
    load_a();
    reset_all();
    start_a();
    model_run(0, 11, 32, 3);
    drain();
    chk("p2_pc", 32'(bus_a.PM_ADDR), 32'd2);
    chk("p2_cycle_cnt", bus_a.CYCLE_CNT, 32'd8);

    // Opcode 11111 then HLT
    stream = '{16'hF955, 16'h0000};
    load_a();
    reset_all();
    start_a();
    model_run(0, 11, 32, 3);
    drain();
    chk("p3_pc", 32'(bus_a.PM_ADDR), 32'd1);
    chk("p3_cycle_cnt", bus_a.CYCLE_CNT, 32'd5);

    // Reset asserted during EXEC of ADDI
    stream = '{16'h1801, 16'h2802, 16'h0000};
    load_a();
    reset_all();
    start_a();
    model_run(0, 11, 32, 3);
    while (qa.size() > 6) void'(qa.pop_back());
    repeat (5) @(posedge CLK);
    #1 RESET = 1'b1;
    chk("addi_exec_wr_acc", {31'd0, bus_a.WR_ACC}, 32'd1);
    chk("addi_exec_operand", 32'(bus_a.OPERAND), 32'd2);
    @(posedge CLK); #1 RESET = 1'b0;
    chk("mid_rst_pc", 32'(bus_a.PM_ADDR), 32'd0);
    chk("mid_rst_cycle_cnt", bus_a.CYCLE_CNT, 32'd0);
    chk("mid_rst_wr_acc", {31'd0, bus_a.WR_ACC}, 32'd0);
    chk("mid_rst_halted", {31'd0, bus_a.HALTED}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_rst_idle_cnt", bus_a.CYCLE_CNT, 32'd0);
    chk("mid_rst_idle_pc", 32'(bus_a.PM_ADDR), 32'd0);

    // PC wrap on the 2-bit PC instance; its 3-bit counter saturates
    stream = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000};
    reset_all();
    bus_b.START = 1'b1;
    @(posedge CLK); #1 bus_b.START = 1'b0;
    model_run(1, 2, 3, 4);
    drain();
    chk("wrap_halted", {31'd0, bus_b.HALTED}, 32'd1);
    chk("wrap_pc", {30'd0, bus_b.PM_ADDR}, 32'd0);
    chk("wrap_cnt_sat", {29'd0, bus_b.CYCLE_CNT}, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP accumulator processor; the instruction-issuing counterpart of the DataPath block.
- Holds the PC and fetches 16-bit instructions from synchronous program memory.
- Decodes a 5-bit opcode and 11-bit operand, then drives the DataPath selects, ALU op and ACC write, plus data-memory read/write strobes.
- Runs from START until a HLT instruction and keeps a cycle count for debug/UART readout.

Parameters:
- PC_W, 11, program counter / program memory address width
- OPC_W, 5, opcode field width (instruction bits [15:11])
- OPD_W, 11, operand field width (instruction bits [10:0])
- CNT_W, 32, cycle counter width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begin execution from PC=0 (sampled only in IDLE)
- PM_DATA  in  16  program memory read data; valid the cycle after PM_ADDR is presented
- PM_ADDR  out  PC_W  program memory address (= PC)
- DM_ADDR  out  OPD_W  data memory address (= IR operand)
- RD_RAM  out  1  data memory read enable
- WR_RAM  out  1  data memory write enable (stores ACC)
- OPERAND  out  OPD_W  operand to DataPath OPERAND_IN
- SEL_A  out  2  ACC source: 0=DM_IN, 1=operand (sign-extended by DataPath), 2=ALU result
- SEL_B  out  1  ALU B source: 0=DM_IN, 1=operand
- WR_ACC  out  1  ACC write enable
- OP  out  1  ALU op: 1=add, 0=subtract
- HALTED  out  1  high while in HALT
- CYCLE_CNT  out  CNT_W  executed-cycle count

Behaviour:
- Reset: state=IDLE, PC=0, IR=0, CYCLE_CNT=0. All strobes (RD_RAM, WR_RAM, WR_ACC, HALTED) are 0. SEL_A=0, SEL_B=0, OP=0, OPERAND=0, DM_ADDR=0, PM_ADDR=0. Reset overrides any state, including mid-instruction; a write in flight is dropped.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE -> FETCH when START=1; otherwise stay.
  - FETCH -> DECODE. PM_ADDR=PC; memory returns PM_DATA in DECODE.
  - DECODE: IR <= PM_DATA. DM_ADDR and OPERAND are driven from PM_DATA[10:0] combinationally this cycle, then from IR. RD_RAM=1 if opcode is LD, ADD or SUB. If opcode=HLT -> HALT, else -> EXEC.
  - EXEC: controls below asserted for exactly this cycle; PC <= PC+1 (wraps 2^PC_W-1 -> 0); -> FETCH.
  - HALT: sticky until RESET; START ignored; PC frozen at the HLT address.
- CPI = 3 (FETCH, DECODE, EXEC); HLT costs 2 cycles.
- Opcode decode, EXEC-cycle controls only:
  - 00000 HLT: no EXEC.
  - 00001 STO: WR_RAM=1.
  - 00010 LD: SEL_A=0, WR_ACC=1.
  - 00011 LDI: SEL_A=1, WR_ACC=1.
  - 00100 ADD: SEL_A=2, SEL_B=0, OP=1, WR_ACC=1.
  - 00101 ADDI: SEL_A=2, SEL_B=1, OP=1, WR_ACC=1.
  - 00110 SUB: SEL_A=2, SEL_B=0, OP=0, WR_ACC=1.
  - 00111 SUBI: SEL_A=2, SEL_B=1, OP=0, WR_ACC=1.
  - Any other opcode: NOP; no strobes, PC still advances.
- Outside EXEC, WR_ACC=WR_RAM=0. RD_RAM stays high through EXEC for memory-operand ops, so DM_IN is valid there. DM_ADDR and OPERAND hold the IR operand during EXEC.
- CYCLE_CNT increments by 1 in every FETCH, DECODE and EXEC cycle. It holds in IDLE and HALT and saturates at all-ones (no wrap).
- HALTED is registered high on the first HALT cycle.

Test Plan:
- Reset mid-run: assert RESET during EXEC of ADDI -> next cycle state IDLE, PC=0, CYCLE_CNT=0, WR_ACC=0, HALTED=0.
- Program LDI 5; ADDI 3; STO 7; HLT, START pulsed once:
  - EXEC cycles show (SEL_A=1, WR_ACC=1, OPERAND=5), then (SEL_A=2, SEL_B=1, OP=1, OPERAND=3), then (WR_RAM=1, DM_ADDR=7).
  - HALTED=1, PC=3, CYCLE_CNT=11.
- Memory ops LD 2; SUB 4; HLT: RD_RAM=1 in DECODE and EXEC of both; DM_ADDR=2 then 4; SUB EXEC has SEL_A=2, SEL_B=0, OP=0; CYCLE_CNT=8.
- Illegal opcode 11111 followed by HLT: no strobes during its EXEC, PC advances 0->1, halts at PC=1, CYCLE_CNT=5.
- START held high in HALT and START=0 in IDLE: no state change, CYCLE_CNT constant over 20 cycles.
- PC wrap with PC_W=2: four NOPs, HLT at address 0 on the second pass -> PC wraps 3->0 and halts at PC=0.
